seg7_frame_decoder: RTL

- Receiving end of the seven-segment display path: per-digit decoders turn a BCD digit into segment lines; this block takes segment patterns back into BCD.
- Accepts one 7-bit segment pattern per valid/ready transfer and decodes it to a 4-bit code.
- Assembles DIGITS consecutive codes into one packed BCD word, presented downstream with a valid/ready handshake.
- Flags and counts illegal patterns. Used for display loop-back checking and for readback of segment-driven outputs.

---
 rtl/seg7_frame_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg7_frame_decoder.sv
// Seven-segment frame decoder: turns a stream of segment patterns (abcdefg)
// back into BCD codes, packs DIGITS of them into one frame, flags frames
// containing illegal patterns and keeps a saturating illegal-pattern count.
module seg7_frame_decoder #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic                  in_first,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  frame_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  resync,
    output logic [CNT_W-1:0]      err_count
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   asm_q, asm_d;     // frame under assembly
    logic                  acc_err_q, acc_err_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;     // last completed frame
    logic                  ferr_q, ferr_d;
    logic                  resync_q, resync_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [3:0]            code;
    logic                  illegal;
    logic                  restart;
    logic [IDX_W-1:0]      slot;
    logic                  err_now;

    // Segment pattern to BCD code; blank maps to 4'hA, anything unknown to 4'hF.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        code    = 4'hF;
        illegal = 1'b0;
        case (seg_in)
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b1011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1111011: code = 4'h9;
            7'b0000000: code = 4'hA;
            default: begin
                code    = 4'hF;
                illegal = 1'b1;
            end
        endcase
    end

    // Next-state logic: digit collection, restart on in_first, frame hand-off.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        acc_err_d = acc_err_q;
        bcd_d     = bcd_q;
        ferr_d    = ferr_q;
        resync_d  = 1'b0;
        cnt_d     = cnt_q;
        restart   = 1'b0;
        slot      = idx_q;
        err_now   = acc_err_q;

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    // A first-digit marker mid-frame throws away the partial
                    // frame and reuses this digit as slot 0 of a fresh one.
                    restart  = in_first && (idx_q != '0);
                    slot     = restart ? '0 : idx_q;
                    resync_d = restart;
                    // Error flag starts fresh whenever this digit opens a frame.
                    err_now  = illegal || (acc_err_q && (slot != '0));

                    for (int k = 0; k < DIGITS; k++) begin
                        if (int'(slot) == DIGITS - 1 - k) begin
                            asm_d[k*4 +: 4] = code;
                        end
                    end

                    if (illegal && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end

                    if (slot == LAST_IDX) begin
                        bcd_d     = asm_d;
                        ferr_d    = err_now;
                        acc_err_d = 1'b0;
                        idx_d     = '0;
                        state_d   = OUTPUT;
                    end else begin
                        acc_err_d = err_now;
                        idx_d     = slot + IDX_W'(1);
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled before the edge.
        if (!rst_n) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            // NOTE: the assembly buffer is reset only to keep simulation free
            // of X; every slot is rewritten before a frame is ever presented.
            asm_q     <= '0;
            acc_err_q <= 1'b0;
            bcd_q     <= '0;
            ferr_q    <= 1'b0;
            resync_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            acc_err_q <= acc_err_d;
            bcd_q     <= bcd_d;
            ferr_q    <= ferr_d;
            resync_q  <= resync_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshake outputs come straight from registered state, so in_ready
    // never follows out_ready combinationally.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == OUTPUT);
    assign bcd_out   = bcd_q;
    assign frame_err = ferr_q;
    assign resync    = resync_q;
    assign err_count = cnt_q;

endmodule
